// File: rtl/sh_mem_port_pkg.sv
// Shared constants for the per-core shared-memory initiator: widths, enable
// encodings and FSM state encoding.
package sh_mem_port_pkg;

   localparam int REG_SIZE     = 8;
   localparam int ADDR_SIZE    = 12;
   localparam int ENABLE_RANGE = 2;

   localparam logic [ENABLE_RANGE-1:0] MEM_EN_IDLE = 2'b00;
   localparam logic [ENABLE_RANGE-1:0] MEM_EN_RD   = 2'b01;
   localparam logic [ENABLE_RANGE-1:0] MEM_EN_WR   = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RD_WAIT = 2'd1,
      ST_WR_WAIT = 2'd2
   } state_t;

endpackage

// File: rtl/sh_mem_port_timer.sv
// Wait counter with timeout compare, plus a saturating count of all stalled
// wait cycles seen since reset.
module sh_mem_port_timer #(
   parameter int TIMEOUT  = 64,
   parameter int CNT_SIZE = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic                in_wait,
   input  logic                mem_ready,
   output logic                timeout,
   output logic [CNT_SIZE-1:0] stall_cnt
);

   logic [CNT_SIZE-1:0] wait_cnt;
   logic                stalled;

   assign stalled = in_wait & ~mem_ready;

   // Fires in the last tolerated stalled cycle; mem_ready in that cycle masks it.
   assign timeout = (TIMEOUT != 0) && stalled && (wait_cnt == CNT_SIZE'(TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         wait_cnt <= '0;
      end else if (start) begin
         wait_cnt <= '0;
      end else if (stalled) begin
         wait_cnt <= wait_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt <= '0;
      end else if (stalled && (stall_cnt != '1)) begin
         stall_cnt <= stall_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/sh_mem_port.sv
// Per-core shared-memory initiator: one outstanding load/store, registered
// request toward the bank arbiter, single-cycle completion pulse to the core.
//
//   state      | meaning
//   ST_IDLE    | no request outstanding, mem_enable idle
//   ST_RD_WAIT | load issued, holding enable=01 until mem_ready or timeout
//   ST_WR_WAIT | store issued, holding enable=10 until mem_ready or timeout
module sh_mem_port #(
   parameter int REG_SIZE  = sh_mem_port_pkg::REG_SIZE,
   parameter int ADDR_SIZE = sh_mem_port_pkg::ADDR_SIZE,
   parameter int TIMEOUT   = 64,
   parameter int CNT_SIZE  = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic                 req_we,
   input  logic [ADDR_SIZE-1:0] req_addr,
   input  logic [REG_SIZE-1:0]  req_wdata,
   output logic                 resp_valid,
   output logic [REG_SIZE-1:0]  resp_rdata,
   output logic                 resp_err,
   output logic [1:0]           mem_enable,
   output logic [ADDR_SIZE-1:0] mem_addr,
   output logic [REG_SIZE-1:0]  mem_wr_data,
   input  logic [REG_SIZE-1:0]  mem_rd_data,
   input  logic                 mem_ready,
   output logic [CNT_SIZE-1:0]  stall_cnt
);

   import sh_mem_port_pkg::*;

   state_t state_q;
   state_t state_d;
   logic   in_wait;
   logic   timeout;
   logic   complete;
   logic   accept;

   sh_mem_port_timer #(
      .TIMEOUT  (TIMEOUT),
      .CNT_SIZE (CNT_SIZE)
   ) u_timer (
      .clk       (clk),
      .reset     (reset),
      .start     (accept),
      .in_wait   (in_wait),
      .mem_ready (mem_ready),
      .timeout   (timeout),
      .stall_cnt (stall_cnt)
   );

   assign in_wait   = (state_q == ST_RD_WAIT) || (state_q == ST_WR_WAIT);
   assign complete  = in_wait && (mem_ready || timeout);
   // Ready in the completing cycle lets the next request issue with no idle gap.
   assign req_ready = (state_q == ST_IDLE) || complete;
   assign accept    = req_valid && req_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (accept) begin
         state_d = req_we ? ST_WR_WAIT : ST_RD_WAIT;
      end else if (complete) begin
         state_d = ST_IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mem_enable  <= MEM_EN_IDLE;
         mem_addr    <= '0;
         mem_wr_data <= '0;
         resp_valid  <= 1'b0;
         resp_rdata  <= '0;
         resp_err    <= 1'b0;
      end else begin
         resp_valid <= complete;
         resp_err   <= complete && !mem_ready;
         if (complete) begin
            resp_rdata <= ((state_q == ST_RD_WAIT) && mem_ready) ? mem_rd_data : '0;
         end
         if (accept) begin
            mem_enable  <= req_we ? MEM_EN_WR : MEM_EN_RD;
            mem_addr    <= req_addr;
            mem_wr_data <= req_wdata;
         end else if (complete) begin
            mem_enable <= MEM_EN_IDLE;
         end
      end
   end

endmodule

// File: tb/tb_sh_mem_port.sv
// Randomized bench for sh_mem_port: the bench acts as both core and memory,
// predicts each completion from a simple memory model, and a monitor scores it.
module tb_sh_mem_port;

   localparam int RS  = 8;
   localparam int AS  = 12;
   localparam int TO  = 8;
   localparam int CS  = 16;
   localparam int NRQ = 120;

   logic          clk = 1'b0;
   logic          reset;
   logic          req_valid;
   logic          req_ready;
   logic          req_we;
   logic [AS-1:0] req_addr;
   logic [RS-1:0] req_wdata;
   logic          resp_valid;
   logic [RS-1:0] resp_rdata;
   logic          resp_err;
   logic [1:0]    mem_enable;
   logic [AS-1:0] mem_addr;
   logic [RS-1:0] mem_wr_data;
   logic [RS-1:0] mem_rd_data;
   logic          mem_ready;
   logic [CS-1:0] stall_cnt;

   sh_mem_port #(
      .REG_SIZE  (RS),
      .ADDR_SIZE (AS),
      .TIMEOUT   (TO),
      .CNT_SIZE  (CS)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_we      (req_we),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .resp_valid  (resp_valid),
      .resp_rdata  (resp_rdata),
      .resp_err    (resp_err),
      .mem_enable  (mem_enable),
      .mem_addr    (mem_addr),
      .mem_wr_data (mem_wr_data),
      .mem_rd_data (mem_rd_data),
      .mem_ready   (mem_ready),
      .stall_cnt   (stall_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          we;
      logic [AS-1:0] addr;
      logic [RS-1:0] wdata;
      int            d;      // stalled cycles before mem_ready; >= TO means never
      bit            b2b;    // presented while the previous request is still waiting
   } req_t;

   typedef struct packed {
      logic          err;
      logic [RS-1:0] rdata;
      logic [CS-1:0] stall;
   } resp_t;

   resp_t         exp_q[$];
   resp_t         mon_e;
   logic [RS-1:0] mem_model [4096];
   int            stall_model = 0;
   int            n_checks = 0;
   int            n_err = 0;
   req_t          rq [NRQ];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   // Monitor: every response pulse must match the oldest predicted completion.
   always @(posedge clk) begin
      #1;
      if (resp_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL unexpected_resp: got resp_valid=1 expected no response at %0t", $time);
         end else begin
            mon_e = exp_q.pop_front();
            check("resp_err", 32'(resp_err), 32'(mon_e.err));
            check("resp_rdata", 32'(resp_rdata), 32'(mon_e.rdata));
            check("stall_cnt", 32'(stall_cnt), 32'(mon_e.stall));
         end
      end
   end

   task automatic drive_req(input req_t r);
      req_valid = 1'b1;
      req_we    = r.we;
      req_addr  = r.addr;
      req_wdata = r.wdata;
   endtask

   // Idle cycles with spurious mem_ready, then present r from idle; returns at accepting edge.
   task automatic issue_idle(input req_t r, input int gap);
      for (int g = 0; g < gap; g++) begin
         @(negedge clk);
         req_valid   = 1'b0;
         mem_ready   = 1'($urandom);
         mem_rd_data = RS'($urandom);
         #1;
         check("idle_req_ready", 32'(req_ready), 32'd1);
         check("idle_enable", 32'(mem_enable), 32'd0);
      end
      @(negedge clk);
      check("pre_issue_enable", 32'(mem_enable), 32'd0);
      drive_req(r);
      mem_ready   = 1'($urandom);
      mem_rd_data = RS'($urandom);
      #1;
      check("issue_req_ready", 32'(req_ready), 32'd1);
      @(posedge clk);
   endtask

   // Serve one accepted request as the memory; optionally present nx for back-to-back issue.
   task automatic run_req(input req_t r, input req_t nx, input bit b2b);
      bit done;
      int inc;
      resp_t e;
      for (int i = 0; i < TO; i++) begin
         @(negedge clk);
         check("hold_enable", 32'(mem_enable), r.we ? 32'd2 : 32'd1);
         check("hold_addr", 32'(mem_addr), 32'(r.addr));
         if (r.we) check("hold_wdata", 32'(mem_wr_data), 32'(r.wdata));
         done        = (i == r.d) || (i == TO - 1);
         mem_ready   = (i == r.d);
         mem_rd_data = (i == r.d && !r.we) ? mem_model[r.addr] : RS'($urandom);
         if (b2b) drive_req(nx);
         else begin
            req_valid = 1'b0;
            req_we    = 1'($urandom);
            req_addr  = AS'($urandom);
         end
         #1;
         check("wait_req_ready", 32'(req_ready), 32'(done));
         if (done) begin
            e.err   = (r.d >= TO);
            e.rdata = (!e.err && !r.we) ? mem_model[r.addr] : '0;
            inc     = e.err ? TO : r.d;
            stall_model = (stall_model + inc > 32'hFFFF) ? 32'hFFFF : stall_model + inc;
            e.stall = CS'(stall_model);
            exp_q.push_back(e);
            if (!e.err && r.we) mem_model[r.addr] = r.wdata;
         end
         @(posedge clk);
         if (done) break;
      end
   endtask

   function automatic req_t rand_req();
      req_t r;
      r.we    = 1'($urandom);
      r.addr  = (AS'($urandom_range(0, 3)) << 8) | AS'($urandom_range(0, 3));
      r.wdata = RS'($urandom);
      r.d     = ($urandom_range(0, 9) == 0) ? TO + 1 : int'($urandom_range(0, TO - 1));
      r.b2b   = ($urandom_range(0, 2) == 0);
      return r;
   endfunction

   req_t ra, rb;

   initial begin
      for (int i = 0; i < 4096; i++) mem_model[i] = '0;
      mem_model[12'h105] = 8'hA5;
      reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
      mem_ready = 1'b0; mem_rd_data = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_enable", 32'(mem_enable), 32'd0);
      check("rst_addr", 32'(mem_addr), 32'd0);
      check("rst_wdata", 32'(mem_wr_data), 32'd0);
      check("rst_resp_valid", 32'(resp_valid), 32'd0);
      check("rst_rdata", 32'(resp_rdata), 32'd0);
      check("rst_err", 32'(resp_err), 32'd0);
      check("rst_stall", 32'(stall_cnt), 32'd0);
      check("rst_req_ready", 32'(req_ready), 32'd1);
      @(negedge clk);
      reset = 1'b0;

      // Read, ready one cycle after grant.
      ra = '{we: 1'b0, addr: 12'h105, wdata: 8'h00, d: 1, b2b: 1'b0};
      issue_idle(ra, 0);
      run_req(ra, ra, 1'b0);
      // Write held through five stalled cycles.
      ra = '{we: 1'b1, addr: 12'h203, wdata: 8'h3C, d: 5, b2b: 1'b0};
      issue_idle(ra, 1);
      run_req(ra, ra, 1'b0);
      // Store then load back-to-back.
      ra = '{we: 1'b1, addr: 12'h210, wdata: 8'h5A, d: 2, b2b: 1'b0};
      rb = '{we: 1'b0, addr: 12'h203, wdata: 8'h00, d: 1, b2b: 1'b1};
      issue_idle(ra, 2);
      run_req(ra, rb, 1'b1);
      run_req(rb, rb, 1'b0);
      // Timeout: mem_ready never arrives.
      ra = '{we: 1'b0, addr: 12'h105, wdata: 8'h00, d: TO + 1, b2b: 1'b0};
      issue_idle(ra, 0);
      run_req(ra, ra, 1'b0);
      // Reset while waiting on a read.
      ra = '{we: 1'b0, addr: 12'h0C1, wdata: 8'h00, d: 0, b2b: 1'b0};
      issue_idle(ra, 3);
      repeat (2) begin
         @(negedge clk);
         req_valid = 1'b0;
         mem_ready = 1'b0;
      end
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("midrst_enable", 32'(mem_enable), 32'd0);
      check("midrst_stall", 32'(stall_cnt), 32'd0);
      check("midrst_resp_valid", 32'(resp_valid), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      stall_model = 0;
      ra = '{we: 1'b0, addr: 12'h105, wdata: 8'h00, d: 3, b2b: 1'b0};
      issue_idle(ra, 2);
      run_req(ra, ra, 1'b0);

      // Randomized traffic.
      for (int k = 0; k < NRQ; k++) rq[k] = rand_req();
      rq[0].b2b = 1'b0;
      issue_idle(rq[0], int'($urandom_range(0, 2)));
      for (int k = 0; k < NRQ; k++) begin
         if (k + 1 < NRQ && rq[k + 1].b2b) begin
            run_req(rq[k], rq[k + 1], 1'b1);
         end else begin
            run_req(rq[k], rq[k], 1'b0);
            if (k + 1 < NRQ) issue_idle(rq[k + 1], int'($urandom_range(0, 2)));
         end
      end

      @(negedge clk);
      req_valid = 1'b0;
      mem_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("pending_responses", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/sh_mem_port.md
Name: sh_mem_port

Overview:
- Per-core initiator for the shared-memory bank arbiter.
- Accepts one load/store at a time from the core pipeline over a valid/ready handshake.
- Drives the core's 2-bit enable, address and write-data slice toward shared memory, holds the request until the arbiter signals ready, and returns read data plus completion status to the core.
- One instance per core; outputs concatenate into the arbiter's enable/addr/wr_data buses.

Parameters:
- REG_SIZE, `REG_SIZE: data width and in-bank word address width.
- ADDR_SIZE, `ADDR_SIZE: full address width, {bank_id, word_addr}.
- TIMEOUT, 64: maximum wait cycles before an outstanding request is aborted; 0 disables the timeout.
- CNT_SIZE, 16: width of the stall counter.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  core presents a request
- req_ready  out  1  port accepts the request this cycle
- req_we  in  1  1 = store, 0 = load
- req_addr  in  ADDR_SIZE  request address
- req_wdata  in  REG_SIZE  store data
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  REG_SIZE  load data; 0 for stores and errors
- resp_err  out  1  completion was a timeout abort
- mem_enable  out  2  2'b01 read, 2'b10 write, 2'b00 idle
- mem_addr  out  ADDR_SIZE  address to shared memory
- mem_wr_data  out  REG_SIZE  write data to shared memory
- mem_rd_data  in  REG_SIZE  read data from shared memory
- mem_ready  in  1  shared-memory completion for this core
- stall_cnt  out  CNT_SIZE  total cycles spent waiting, saturating

Behaviour:
- FSM states: IDLE, RD_WAIT, WR_WAIT. Reset (synchronous, active-high, clock clk) forces IDLE.
- Reset values of all registered outputs: mem_enable=00, mem_addr=0, mem_wr_data=0, resp_valid=0, resp_rdata=0, resp_err=0, stall_cnt=0; internal wait counter = 0.
- req_ready is combinational: 1 in IDLE; 1 in RD_WAIT/WR_WAIT only in a completing cycle (mem_ready=1 or timeout). This allows back-to-back issue.
- Accept: on req_valid & req_ready, register addr and wdata, and set mem_enable to 10 if req_we else 01 from the next cycle.
  - Next state is WR_WAIT or RD_WAIT.
  - Wait counter clears.
  - mem_* outputs come from registers; no combinational path from req_* to mem_*.
- Hold rule: mem_enable, mem_addr and mem_wr_data stay stable while in a WAIT state until completion.
- Write protocol:
  - mem_ready is asserted in the same cycle the arbiter grants the write.
  - In that cycle the FSM leaves WR_WAIT and drops mem_enable (or loads the next accepted request) at the following edge, so exactly one write is issued.
  - resp_valid=1 and resp_rdata=0 one cycle after that mem_ready.
- Read protocol:
  - mem_ready is asserted the cycle after the grant, with mem_rd_data valid only in that cycle.
  - The port keeps enable=01 through the grant cycle and the ready cycle; a duplicate read grant in the ready cycle is harmless and its result is ignored.
  - On mem_ready in RD_WAIT, capture mem_rd_data into resp_rdata; resp_valid=1 the next cycle.
- mem_ready outside a WAIT state is ignored and does not count as a completion.
- resp_valid is a single-cycle pulse; resp_rdata holds its value until the next completion.
- Timeout:
  - The wait counter increments every WAIT cycle without mem_ready.
  - When TIMEOUT≠0 and the counter reaches TIMEOUT-1 without mem_ready, the next cycle gives resp_valid=1, resp_err=1, resp_rdata=0.
  - The FSM returns to IDLE (or a newly accepted request) and drops mem_enable.
  - mem_ready in the same cycle as the timeout wins: normal completion, no error.
- stall_cnt increments by 1 each cycle in RD_WAIT/WR_WAIT with mem_ready=0, and saturates at all-ones.
- Reset mid-request: the request is abandoned, no resp_valid is produced, and mem_enable=00 from the next cycle.

Decomposition:
- The shared include carries:
  - enable encodings as named constants: MEM_EN_IDLE=2'b00, MEM_EN_RD=2'b01, MEM_EN_WR=2'b10;
  - FSM state constants (2-bit);
  - ADDR_SIZE, REG_SIZE, ENABLE_RANGE.
- One natural sub-module: sh_mem_port_timer, which holds the wait counter, timeout compare and saturating stall_cnt.
- The FSM and datapath registers stay in sh_mem_port.

Test Plan:
- Read, granted 1 cycle after issue: req addr=0x105 we=0 -> mem_enable=01, mem_addr=0x105; mem_ready at cycle 3 with mem_rd_data=0xA5 -> resp_valid pulse at cycle 4, resp_rdata=0xA5, resp_err=0.
- Write with 5-cycle contention: req addr=0x203 wdata=0x3C -> mem_enable=10 held 5 cycles; mem_ready once -> exactly one write cycle, resp_valid next cycle, stall_cnt=5.
- Back-to-back: store then load kept valid continuously -> second request accepted in the store's ready cycle, mem_enable goes 10 then 01 with no idle cycle between.
- Timeout with TIMEOUT=4, mem_ready never asserted -> resp_valid with resp_err=1, resp_rdata=0 after 4 wait cycles; mem_enable=00 afterwards.
- Reset asserted while in RD_WAIT -> next cycle mem_enable=00, resp_valid stays 0, stall_cnt=0; a subsequent read completes normally.
- Spurious mem_ready while in IDLE -> no resp_valid, state unchanged.
